// File: rtl/v_lsu_sched_pkg.sv
// Shared types and constants for the vector load/store scheduler.
// Bank index is the low two bits of the word address.
package v_lsu_sched_pkg;

  localparam int DATAMEM_BITS  = 14;
  localparam int DATAMEM_WIDTH = 32;
  localparam int NBANK         = 4;

  typedef logic [DATAMEM_BITS-1:0]  daddr_t;
  typedef logic [DATAMEM_WIDTH-1:0] dword_t;

  typedef enum logic [1:0] {
    VLSU_IDLE  = 2'd0,
    VLSU_ISSUE = 2'd1,
    VLSU_DRAIN = 2'd2,
    VLSU_DONE  = 2'd3
  } vlsu_state_e;

  function automatic logic [1:0] bank_of(input daddr_t a);
    return a[1:0];
  endfunction

  function automatic logic in_prot(input daddr_t a);
    return a[DATAMEM_BITS-1];
  endfunction

endpackage

// File: rtl/v_lsu_sched_if.sv
// Four-bank data memory port bundle between the scheduler and v_datamem.
// Read data returns one cycle after the address is presented.
interface v_lsu_sched_if;
  import v_lsu_sched_pkg::*;

  logic   [NBANK-1:0][3:0] dm_write;
  daddr_t [NBANK-1:0]      bank_addr;
  dword_t [NBANK-1:0]      bank_wdata;
  dword_t [NBANK-1:0]      bank_rdata;

  modport master (
    output dm_write,
    output bank_addr,
    output bank_wdata,
    input  bank_rdata
  );

  modport slave (
    input  dm_write,
    input  bank_addr,
    input  bank_wdata,
    output bank_rdata
  );

endinterface

// File: rtl/v_lsu_sched_bank_pick.sv
// Picks the longest in-order prefix of candidates with distinct banks,
// stopping before the first candidate in the protocol region.
module v_lsu_bank_pick
  import v_lsu_sched_pkg::*;
(
  input  daddr_t [NBANK-1:0]      cand,
  input  logic   [NBANK-1:0]      valid,
  output logic   [2:0]            cnt,
  output logic   [NBANK-1:0]      issue,
  output logic   [NBANK-1:0]      bank_en,
  output logic   [NBANK-1:0][1:0] bank_lane,
  output logic                    hit,
  output logic   [1:0]            hit_pos
);

  logic [NBANK-1:0] used;
  logic             run;
  logic [1:0]       b;

  always_comb begin
    cnt       = '0;
    issue     = '0;
    bank_en   = '0;
    bank_lane = '0;
    hit       = 1'b0;
    hit_pos   = '0;
    used      = '0;
    run       = 1'b1;
    b         = '0;
    for (int j = 0; j < NBANK; j++) begin
      b = bank_of(cand[j]);
      if (run && valid[j] && !used[b]) begin
        if (in_prot(cand[j])) begin
          hit     = 1'b1;
          hit_pos = 2'(j);
          run     = 1'b0;
        end else begin
          used[b]      = 1'b1;
          issue[j]     = 1'b1;
          bank_en[b]   = 1'b1;
          bank_lane[b] = 2'(j);
          cnt          = cnt + 3'd1;
        end
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/v_lsu_sched.sv
// Vector load/store scheduler: splits one strided vector op into
// conflict-free per-cycle word accesses on the four data memory banks.
module v_lsu_sched
  import v_lsu_sched_pkg::*;
#(
  parameter  int VLMAX = 32,
  localparam int VLW   = $clog2(VLMAX) + 1,
  localparam int IW    = $clog2(VLMAX)
) (
  input  logic                           core_clk,
  input  logic                           nrst,
  input  logic                           start,
  input  logic                           is_store,
  input  daddr_t                         base_addr,
  input  daddr_t                         stride,
  input  logic [VLW-1:0]                 vl,
  input  logic [VLMAX*DATAMEM_WIDTH-1:0] vs3_data,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  v_lsu_sched_if.master                  bank,
  output logic [NBANK-1:0]               wb_valid,
  output logic [NBANK-1:0][IW-1:0]       wb_idx,
  output dword_t [NBANK-1:0]             wb_data
);

  vlsu_state_e state, nxt;

  logic [VLW-1:0]                 idx, vl_r;
  daddr_t                         cur, stride_r;
  logic                           st_r, err_r;
  logic [VLMAX*DATAMEM_WIDTH-1:0] data_r;

  logic [NBANK-1:0]          pv;
  logic [NBANK-1:0][1:0]     pb;
  logic [NBANK-1:0][IW-1:0]  pi;

  daddr_t [NBANK-1:0]      cand;
  logic   [NBANK-1:0]      cvalid;
  logic   [2:0]            cnt;
  logic   [NBANK-1:0]      issue;
  logic   [NBANK-1:0]      bank_en;
  logic   [NBANK-1:0][1:0] bank_lane;
  logic                    hit;
  logic   [1:0]            hit_pos;
  logic   [2:0]            adv;
  logic                    last;

  logic   [NBANK-1:0][3:0] dmw;
  daddr_t [NBANK-1:0]      ba;
  dword_t [NBANK-1:0]      bw;
  logic   [IW-1:0]         e;

  always_comb begin
    for (int j = 0; j < NBANK; j++) begin
      cand[j]   = cur + daddr_t'(j) * stride_r;
      cvalid[j] = (int'(idx) + j) < int'(vl_r);
    end
  end

  v_lsu_bank_pick u_pick (
    .cand      (cand),
    .valid     (cvalid),
    .cnt       (cnt),
    .issue     (issue),
    .bank_en   (bank_en),
    .bank_lane (bank_lane),
    .hit       (hit),
    .hit_pos   (hit_pos)
  );

  assign adv  = hit ? {1'b0, hit_pos} : cnt;
  assign last = hit || ((int'(idx) + int'(cnt)) >= int'(vl_r));

  always_ff @(posedge core_clk) begin
    if (!nrst) state <= VLSU_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      VLSU_IDLE: begin
        if (start) nxt = (vl == '0) ? VLSU_DONE : VLSU_ISSUE;
      end
      VLSU_ISSUE: begin
        if (last) nxt = st_r ? VLSU_DONE : VLSU_DRAIN;
      end
      VLSU_DRAIN: nxt = VLSU_DONE;
      VLSU_DONE:  nxt = VLSU_IDLE;
      default:    nxt = VLSU_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != VLSU_IDLE);
    done = (state == VLSU_DONE);
    err  = err_r;
  end

  always_ff @(posedge core_clk) begin
    if (!nrst) begin
      idx      <= '0;
      vl_r     <= '0;
      cur      <= '0;
      stride_r <= '0;
      st_r     <= 1'b0;
      err_r    <= 1'b0;
      data_r   <= '0;
      pv       <= '0;
      pb       <= '0;
      pi       <= '0;
    end else begin
      pv <= '0;
      if (state == VLSU_IDLE && start) begin
        idx      <= '0;
        vl_r     <= vl;
        cur      <= base_addr;
        stride_r <= stride;
        st_r     <= is_store;
        err_r    <= 1'b0;
        data_r   <= vs3_data;
      end
      if (state == VLSU_ISSUE) begin
        idx <= idx + VLW'(adv);
        cur <= cur + daddr_t'(adv) * stride_r;
        if (hit) err_r <= 1'b1;
        // lane l returns element idx+l from the bank it was routed to
        if (!st_r) pv <= issue;
        for (int l = 0; l < NBANK; l++) begin
          pb[l] <= cand[l][1:0];
          pi[l] <= IW'(int'(idx) + l);
        end
      end
    end
  end

  always_comb begin
    dmw = '0;
    ba  = '0;
    bw  = '0;
    e   = '0;
    if (state == VLSU_ISSUE) begin
      for (int b = 0; b < NBANK; b++) begin
        if (bank_en[b]) begin
          ba[b] = cand[bank_lane[b]];
          if (st_r) begin
            e      = IW'(int'(idx) + int'(bank_lane[b]));
            dmw[b] = 4'hF;
            bw[b]  = data_r[int'(e)*DATAMEM_WIDTH +: DATAMEM_WIDTH];
          end
        end
      end
    end
  end

  assign bank.dm_write   = dmw;
  assign bank.bank_addr  = ba;
  assign bank.bank_wdata = bw;

  always_comb begin
    wb_valid = pv;
    for (int l = 0; l < NBANK; l++) begin
      wb_idx[l]  = pv[l] ? pi[l] : '0;
      wb_data[l] = pv[l] ? bank.bank_rdata[pb[l]] : '0;
    end
  end

endmodule

// File: tb/tb_v_lsu_sched.sv
// Bench for v_lsu_sched: a four-bank memory model plus a throughput-based
// reference model of element grouping, writeback timing and abort.
module tb_v_lsu_sched;
  import v_lsu_sched_pkg::*;

  localparam int VLMAX = 32;

  logic                core_clk = 1'b0;
  logic                nrst = 1'b0;
  logic                start = 1'b0;
  logic                is_store = 1'b0;
  logic [13:0]         base_addr = '0;
  logic [13:0]         stride = '0;
  logic [5:0]          vl = '0;
  logic [VLMAX*32-1:0] vs3_data = '0;
  logic                busy, done, err;
  logic [3:0]          wb_valid;
  logic [3:0][4:0]     wb_idx;
  logic [3:0][31:0]    wb_data;

  v_lsu_sched_if bus();

  v_lsu_sched #(.VLMAX(VLMAX)) dut (
    .core_clk  (core_clk),
    .nrst      (nrst),
    .start     (start),
    .is_store  (is_store),
    .base_addr (base_addr),
    .stride    (stride),
    .vl        (vl),
    .vs3_data  (vs3_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bank      (bus),
    .wb_valid  (wb_valid),
    .wb_idx    (wb_idx),
    .wb_data   (wb_data)
  );

  always #5 core_clk = ~core_clk;

  logic [31:0] mem    [16384];
  logic [31:0] shadow [16384];
  bit          mem_init = 1'b0;

  always @(posedge core_clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 16384; a++) mem[a] <= 32'(a);
      mem_init <= 1'b1;
    end else begin
      for (int k = 0; k < 4; k++)
        if (bus.dm_write[k] == 4'hF)
          mem[bus.bank_addr[k]] <= bus.bank_wdata[k];
    end
    for (int k = 0; k < 4; k++)
      bus.bank_rdata[k] <= mem[bus.bank_addr[k]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 64'({busy, done, err, wb_valid, bus.dm_write,
                  |bus.bank_addr, |bus.bank_wdata,
                  |wb_idx, |wb_data}), 64'd0);
  endtask

  task automatic run_op(input string nm, input bit st,
                        input logic [13:0] b, input logic [13:0] s,
                        input int n, input bit pulse);
    int per, lim, ncyc, exp_done, exp_wcyc;
    bit eerr, oerr;
    logic [13:0] a;
    int ei[$], ec[$], oi[$], oc[$];
    logic [31:0] ed[$], od[$];
    int done_cyc, cyc, viol, wr_cnt, wr_cyc, diffs, m;
    bit any_wr;

    for (int i = 0; i < VLMAX; i++) vs3_data[32*i +: 32] = $urandom();

    // elements per cycle follow from the stride's residue mod 4
    per  = s[0] ? 4 : (s[1] ? 2 : 1);
    lim  = n;
    eerr = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = b + 14'(i) * s;
      if (a[13]) begin
        lim  = i;
        eerr = 1'b1;
        break;
      end
    end
    if (n == 0)    ncyc = 0;
    else if (eerr) ncyc = lim / per + 1;
    else           ncyc = (n + per - 1) / per;
    exp_done = (n == 0) ? 1 : (st ? ncyc + 1 : ncyc + 2);
    exp_wcyc = (st && lim > 0) ? (lim - 1) / per + 1 : 0;
    for (int i = 0; i < lim; i++) begin
      a = b + 14'(i) * s;
      if (st) shadow[a] = vs3_data[32*i +: 32];
      else begin
        ei.push_back(i);
        ed.push_back(shadow[a]);
        ec.push_back(i / per + 2);
      end
    end

    @(negedge core_clk);
    start = 1'b1; is_store = st; base_addr = b;
    stride = s; vl = 6'(n);
    cyc = 0; done_cyc = 0; viol = 0; wr_cnt = 0; wr_cyc = 0;
    oerr = 1'b0;
    while (done_cyc == 0 && cyc < 400) begin
      @(negedge core_clk);
      cyc++;
      any_wr = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (bus.bank_addr[k][13]) viol++;
        if (bus.bank_addr[k] != '0 && bus.bank_addr[k][1:0] != 2'(k))
          viol++;
        if (bus.dm_write[k] != 4'h0) begin
          if (bus.dm_write[k] != 4'hF || !st) viol++;
          wr_cnt++;
          any_wr = 1'b1;
        end else if (bus.bank_wdata[k] != '0) viol++;
        if (st && bus.dm_write[k] == 4'h0 && bus.bank_addr[k] != '0)
          viol++;
      end
      if (any_wr) wr_cyc++;
      if (!(wb_valid inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF})) viol++;
      for (int l = 0; l < 4; l++) begin
        if (wb_valid[l]) begin
          oi.push_back(int'(wb_idx[l]));
          od.push_back(wb_data[l]);
          oc.push_back(cyc);
        end
      end
      if (!busy) viol++;
      if (done) begin
        done_cyc = cyc;
        oerr = err;
      end
      start = pulse && cyc == 1;
      if (start) begin
        vl = 6'($urandom_range(1, 32));
        base_addr = 14'($urandom);
        is_store = ~st;
      end
    end

    @(negedge core_clk);
    start = 1'b0;
    chk({nm, " done_cyc"}, 64'(done_cyc), 64'(exp_done));
    chk({nm, " err"}, 64'(oerr), 64'(eerr));
    chk({nm, " after"}, 64'({done, busy, err}), 64'({2'b00, eerr}));
    chk({nm, " port_viol"}, 64'(viol), 64'd0);
    chk({nm, " wr_cnt"}, 64'(wr_cnt), 64'(st ? lim : 0));
    chk({nm, " wr_cyc"}, 64'(wr_cyc), 64'(exp_wcyc));
    chk({nm, " wb_cnt"}, 64'(oi.size()), 64'(ei.size()));
    m = (oi.size() < ei.size()) ? oi.size() : ei.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s wb_idx[%0d]", nm, i), 64'(oi[i]), 64'(ei[i]));
      chk($sformatf("%s wb_data[%0d]", nm, i), 64'(od[i]), 64'(ed[i]));
      chk($sformatf("%s wb_cyc[%0d]", nm, i), 64'(oc[i]), 64'(ec[i]));
    end
    diffs = 0;
    for (int x = 0; x < 16384; x++) if (mem[x] !== shadow[x]) diffs++;
    chk({nm, " mem"}, 64'(diffs), 64'd0);
    @(negedge core_clk);
    chk({nm, " idle"}, 64'({busy, done}), 64'd0);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          st;
    logic [13:0] b, s;

    for (int a = 0; a < 16384; a++) shadow[a] = 32'(a);
    nrst = 1'b0;
    repeat (3) @(negedge core_clk);
    chk_zero("reset");
    nrst = 1'b1;

    run_op("ld_s1", 1'b0, 14'h0100, 14'd1, 8, 1'b0);
    run_op("st_s2", 1'b1, 14'h0040, 14'd2, 4, 1'b0);
    run_op("ld_s0", 1'b0, 14'h0005, 14'd0, 3, 1'b0);
    run_op("st_prot", 1'b1, 14'h1FFE, 14'd1, 4, 1'b0);
    run_op("vl0", 1'b0, 14'h0010, 14'd1, 0, 1'b1);
    run_op("st_vl4", 1'b1, 14'h0080, 14'd1, 4, 1'b1);
    run_op("ld_vl4", 1'b0, 14'h0080, 14'd1, 4, 1'b0);
    run_op("ld_neg", 1'b0, 14'h0003, 14'h3FFF, 6, 1'b0);
    run_op("ld_full", 1'b0, 14'h0400, 14'd4, 32, 1'b1);

    for (int t = 0; t < 14; t++) begin
      st = 1'($urandom_range(0, 1));
      case (t % 3)
        0:       b = 14'($urandom_range(0, 16'h1FFF));
        1:       b = 14'($urandom_range(16'h1FC0, 16'h1FFF));
        default: b = 14'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 3) == 0) s = 14'($urandom);
      else s = 14'($urandom_range(0, 16)) - 14'd8;
      run_op($sformatf("rnd%0d", t), st, b, s,
             int'($urandom_range(0, 32)), 1'(t % 2));
    end

    @(negedge core_clk);
    start = 1'b1; is_store = 1'b0; base_addr = 14'h0200;
    stride = 14'd1; vl = 6'd16;
    @(negedge core_clk);
    start = 1'b0;
    @(negedge core_clk);
    chk("rst pre wb", 64'(wb_valid), 64'hF);
    nrst = 1'b0;
    @(negedge core_clk);
    chk_zero("rst mid");
    nrst = 1'b1;
    @(negedge core_clk);
    chk_zero("rst after");
    @(negedge core_clk);
    chk_zero("rst after2");
    run_op("post_rst", 1'b0, 14'h0300, 14'd1, 12, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
